// File: rtl/n1_intc_pkg.sv
// Shared constants for the N1 interrupt controller: register map, reset values
// and the layout of the ACTIVE status word.
package n1_intc_pkg;

  localparam logic [3:0] ADR_ENABLE      = 4'h0;
  localparam logic [3:0] ADR_PENDING     = 4'h1;
  localparam logic [3:0] ADR_MODE        = 4'h2;
  localparam logic [3:0] ADR_ACTIVE      = 4'h3;
  localparam logic [3:0] ADR_VECTOR_BASE = 4'h8;

  localparam logic [7:0]  RST_ENABLE  = 8'h00;
  localparam logic [7:0]  RST_PENDING = 8'h00;
  localparam logic [7:0]  RST_MODE    = 8'h00;
  localparam logic [15:0] RST_VECTOR  = 16'h0000;

  localparam int ACTIVE_VLD_BIT  = 15;
  localparam int ACTIVE_LINE_LSB = 0;

  function automatic logic [15:0] active_word(input logic vld, input logic [2:0] line);
    logic [15:0] w;
    w = '0;
    w[ACTIVE_VLD_BIT] = vld;
    w[ACTIVE_LINE_LSB +: 3] = line;
    return w;
  endfunction

endpackage

// File: rtl/n1_intc_sync.sv
// Per-line 2-FF synchronizer with rising-edge detector; all flops clear on reset,
// so a line held high through reset yields an edge at the first sample afterwards.
module n1_intc_sync (
  input  logic clk_i,
  input  logic sync_rst_i,
  input  logic irq_i,
  output logic level_o,
  output logic edge_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = irq_i;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level_o = sync_q;
  assign edge_o  = sync_q & ~prev_q;

endmodule

// File: rtl/n1_intc.sv
// N1 interrupt controller: per-line pending capture, fixed-priority selection and a
// registered ISR address bus, configured through a single-cycle register port.
module n1_intc
  import n1_intc_pkg::*;
#(
  parameter int IRQ_CNT = 8
) (
  input  logic               clk_i,
  input  logic               sync_rst_i,
  input  logic [IRQ_CNT-1:0] irq_i,
  input  logic               irq_ack_i,
  output logic [15:0]        irq_req_adr_o,
  input  logic               reg_stb_i,
  input  logic               reg_we_i,
  input  logic [3:0]         reg_adr_i,
  input  logic [15:0]        reg_dat_i,
  output logic [15:0]        reg_dat_o,
  output logic               reg_ack_o
);

  logic [IRQ_CNT-1:0] lvl, edg;

  for (genvar g = 0; g < IRQ_CNT; g++) begin : g_sync
    n1_intc_sync u_sync (
      .clk_i      (clk_i),
      .sync_rst_i (sync_rst_i),
      .irq_i      (irq_i[g]),
      .level_o    (lvl[g]),
      .edge_o     (edg[g])
    );
  end

  logic [IRQ_CNT-1:0] enable_q, enable_d;
  logic [IRQ_CNT-1:0] mode_q, mode_d;
  logic [IRQ_CNT-1:0] pending_q, pending_d;
  logic [15:0]        vector_q [IRQ_CNT];
  logic [15:0]        vector_d [IRQ_CNT];
  logic [15:0]        irq_req_adr_q, irq_req_adr_d;
  logic               sel_vld_q, sel_vld_d;
  logic [2:0]         sel_line_q, sel_line_d;
  logic [15:0]        reg_dat_q, reg_dat_d;
  logic               reg_ack_q, reg_ack_d;

  logic       wr_en, rd_en, vec_sel;
  logic [2:0] vec_idx;
  logic [15:0] rd_word;

  assign wr_en   = reg_stb_i & reg_we_i;
  assign rd_en   = reg_stb_i & ~reg_we_i;
  assign vec_sel = (reg_adr_i >= ADR_VECTOR_BASE);
  assign vec_idx = 3'(reg_adr_i - ADR_VECTOR_BASE);

  always_comb begin
    enable_d  = enable_q;
    mode_d    = mode_q;
    vector_d  = vector_q;
    pending_d = pending_q;
    rd_word   = '0;

    if (wr_en) begin
      case (reg_adr_i)
        ADR_ENABLE: enable_d = reg_dat_i[IRQ_CNT-1:0];
        ADR_MODE:   mode_d   = reg_dat_i[IRQ_CNT-1:0];
        default: begin
          for (int i = 0; i < IRQ_CNT; i++)
            if (vec_sel && vec_idx == 3'(i)) vector_d[i] = reg_dat_i;
        end
      endcase
    end

    // Edge lines latch; level lines track the synchronized input. Set beats clear.
    for (int i = 0; i < IRQ_CNT; i++) begin
      if (mode_q[i]) begin
        if (wr_en && reg_adr_i == ADR_PENDING && reg_dat_i[i]) pending_d[i] = 1'b0;
        if (irq_ack_i && sel_vld_q && sel_line_q == 3'(i))    pending_d[i] = 1'b0;
        if (edg[i])                                           pending_d[i] = 1'b1;
      end else begin
        pending_d[i] = lvl[i];
      end
    end

    case (reg_adr_i)
      ADR_ENABLE:  rd_word = 16'(enable_q);
      ADR_PENDING: rd_word = 16'(pending_q);
      ADR_MODE:    rd_word = 16'(mode_q);
      ADR_ACTIVE:  rd_word = active_word(sel_vld_q, sel_line_q);
      default: begin
        for (int i = 0; i < IRQ_CNT; i++)
          if (vec_sel && vec_idx == 3'(i)) rd_word = vector_q[i];
      end
    endcase
  end

  // Walk from the lowest priority up so the lowest eligible index is left standing.
  always_comb begin
    sel_vld_d     = 1'b0;
    sel_line_d    = '0;
    irq_req_adr_d = '0;
    for (int i = IRQ_CNT - 1; i >= 0; i--) begin
      if (pending_q[i] && enable_q[i] && vector_q[i] != 16'h0000) begin
        sel_vld_d     = 1'b1;
        sel_line_d    = 3'(i);
        irq_req_adr_d = vector_q[i];
      end
    end
    reg_dat_d = rd_en ? rd_word : 16'h0000;
    reg_ack_d = reg_stb_i;
  end

  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      enable_q      <= RST_ENABLE[IRQ_CNT-1:0];
      mode_q        <= RST_MODE[IRQ_CNT-1:0];
      pending_q     <= RST_PENDING[IRQ_CNT-1:0];
      vector_q      <= '{default: RST_VECTOR};
      irq_req_adr_q <= '0;
      sel_vld_q     <= 1'b0;
      sel_line_q    <= '0;
      reg_dat_q     <= '0;
      reg_ack_q     <= 1'b0;
    end else begin
      enable_q      <= enable_d;
      mode_q        <= mode_d;
      pending_q     <= pending_d;
      vector_q      <= vector_d;
      irq_req_adr_q <= irq_req_adr_d;
      sel_vld_q     <= sel_vld_d;
      sel_line_q    <= sel_line_d;
      reg_dat_q     <= reg_dat_d;
      reg_ack_q     <= reg_ack_d;
    end
  end

  assign irq_req_adr_o = irq_req_adr_q;
  assign reg_dat_o     = reg_dat_q;
  assign reg_ack_o     = reg_ack_q;

endmodule

// File: tb/tb_n1_intc.sv
// Directed bench for n1_intc: register-port vector table plus hand-timed
// sequences for request latency, ack, priority, level gating, collisions and reset.
module tb_n1_intc;

  localparam int IRQ_CNT = 8;

  logic         clk_i = 1'b0;
  logic         sync_rst_i;
  logic [7:0]   irq_i;
  logic         irq_ack_i;
  logic [15:0]  irq_req_adr_o;
  logic         reg_stb_i;
  logic         reg_we_i;
  logic [3:0]   reg_adr_i;
  logic [15:0]  reg_dat_i;
  logic [15:0]  reg_dat_o;
  logic         reg_ack_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  n1_intc #(.IRQ_CNT(IRQ_CNT)) dut (
    .clk_i         (clk_i),
    .sync_rst_i    (sync_rst_i),
    .irq_i         (irq_i),
    .irq_ack_i     (irq_ack_i),
    .irq_req_adr_o (irq_req_adr_o),
    .reg_stb_i     (reg_stb_i),
    .reg_we_i      (reg_we_i),
    .reg_adr_i     (reg_adr_i),
    .reg_dat_i     (reg_dat_i),
    .reg_dat_o     (reg_dat_o),
    .reg_ack_o     (reg_ack_o)
  );

  typedef struct {
    logic        we;
    logic [3:0]  adr;
    logic [15:0] dat;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[14];

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wr(input logic [3:0] adr, input logic [15:0] dat);
    reg_stb_i = 1'b1;
    reg_we_i  = 1'b1;
    reg_adr_i = adr;
    reg_dat_i = dat;
    tick();
    reg_stb_i = 1'b0;
    reg_we_i  = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [3:0] adr, input logic [15:0] exp);
    reg_stb_i = 1'b1;
    reg_we_i  = 1'b0;
    reg_adr_i = adr;
    tick();
    chk({name, "_ack"}, 16'(reg_ack_o), 16'h0001);
    chk(name, reg_dat_o, exp);
    reg_stb_i = 1'b0;
  endtask

  task automatic ack();
    irq_ack_i = 1'b1;
    tick();
    irq_ack_i = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 4'h0, 16'hFFFF, 16'h0000};
    tbl[1]  = '{1'b0, 4'h0, 16'h0000, 16'h00FF};
    tbl[2]  = '{1'b1, 4'h2, 16'hA5A5, 16'h0000};
    tbl[3]  = '{1'b0, 4'h2, 16'h0000, 16'h00A5};
    tbl[4]  = '{1'b1, 4'hF, 16'hBEEF, 16'h0000};
    tbl[5]  = '{1'b0, 4'hF, 16'h0000, 16'hBEEF};
    tbl[6]  = '{1'b1, 4'h4, 16'h1234, 16'h0000};
    tbl[7]  = '{1'b0, 4'h4, 16'h0000, 16'h0000};
    tbl[8]  = '{1'b0, 4'h7, 16'h0000, 16'h0000};
    tbl[9]  = '{1'b1, 4'h0, 16'h0000, 16'h0000};
    tbl[10] = '{1'b0, 4'h0, 16'h0000, 16'h0000};
    tbl[11] = '{1'b1, 4'hF, 16'h0000, 16'h0000};
    tbl[12] = '{1'b1, 4'h2, 16'h0000, 16'h0000};
    tbl[13] = '{1'b0, 4'h3, 16'h0000, 16'h0000};

    sync_rst_i = 1'b1;
    irq_i      = '0;
    irq_ack_i  = 1'b0;
    reg_stb_i  = 1'b0;
    reg_we_i   = 1'b0;
    reg_adr_i  = '0;
    reg_dat_i  = '0;

    // Reset state
    tick();
    tick();
    chk("rst_irq_req", irq_req_adr_o, 16'h0000);
    chk("rst_ack", 16'(reg_ack_o), 16'h0000);
    sync_rst_i = 1'b0;
    tick();
    for (int a = 0; a < 16; a++) rd_chk($sformatf("rst_reg%0d", a), 4'(a), 16'h0000);

    // Register table, strobes back to back
    for (int i = 0; i < 14; i++) begin
      reg_stb_i = 1'b1;
      reg_we_i  = tbl[i].we;
      reg_adr_i = tbl[i].adr;
      reg_dat_i = tbl[i].dat;
      tick();
      chk($sformatf("tbl%0d_ack", i), 16'(reg_ack_o), 16'h0001);
      if (!tbl[i].we) chk($sformatf("tbl%0d_rd", i), reg_dat_o, tbl[i].exp);
    end
    reg_stb_i = 1'b0;
    reg_we_i  = 1'b0;
    tick();
    chk("tbl_ack_idle", 16'(reg_ack_o), 16'h0000);

    // Edge request and ack on line 3
    wr(4'hB, 16'h1234);
    wr(4'h2, 16'h0008);
    wr(4'h0, 16'h0008);
    irq_i = 8'h08;
    tick();
    irq_i = 8'h00;
    tick();
    tick();
    chk("edge_cyc3", irq_req_adr_o, 16'h0000);
    tick();
    chk("edge_cyc4", irq_req_adr_o, 16'h1234);
    tick();
    tick();
    ack();
    chk("ack_k1", irq_req_adr_o, 16'h1234);
    tick();
    chk("ack_k2", irq_req_adr_o, 16'h0000);
    rd_chk("edge_pending", 4'h1, 16'h0000);

    // Priority between lines 1 and 5
    wr(4'h9, 16'h0100);
    wr(4'hD, 16'h0500);
    wr(4'h2, 16'h0022);
    wr(4'h0, 16'h0022);
    irq_i = 8'h22;
    tick();
    irq_i = 8'h00;
    tick();
    tick();
    tick();
    chk("prio_first", irq_req_adr_o, 16'h0100);
    rd_chk("prio_active1", 4'h3, 16'h8001);
    rd_chk("prio_pending", 4'h1, 16'h0022);
    ack();
    tick();
    chk("prio_second", irq_req_adr_o, 16'h0500);
    rd_chk("prio_active5", 4'h3, 16'h8005);
    ack();
    tick();
    chk("prio_none", irq_req_adr_o, 16'h0000);
    rd_chk("prio_pending0", 4'h1, 16'h0000);

    // Level mode with vector gating on line 2
    wr(4'h2, 16'h0000);
    wr(4'h0, 16'h0004);
    irq_i = 8'h04;
    repeat (6) tick();
    chk("lvl_vec0", irq_req_adr_o, 16'h0000);
    rd_chk("lvl_pending", 4'h1, 16'h0004);
    wr(4'hA, 16'h0200);
    chk("lvl_vec_k1", irq_req_adr_o, 16'h0000);
    tick();
    chk("lvl_vec_k2", irq_req_adr_o, 16'h0200);
    ack();
    tick();
    chk("lvl_after_ack", irq_req_adr_o, 16'h0200);
    irq_i = 8'h00;
    tick();
    tick();
    tick();
    chk("lvl_drop3", irq_req_adr_o, 16'h0200);
    tick();
    chk("lvl_drop4", irq_req_adr_o, 16'h0000);

    // Edge landing together with a W1C of the same line
    wr(4'h8, 16'h0A00);
    wr(4'h2, 16'h0001);
    wr(4'h0, 16'h0001);
    irq_i = 8'h01;
    repeat (4) tick();
    chk("col_first", irq_req_adr_o, 16'h0A00);
    irq_i = 8'h00;
    repeat (3) tick();
    chk("col_latched", irq_req_adr_o, 16'h0A00);
    irq_i = 8'h01;
    tick();
    tick();
    wr(4'h1, 16'h0001);
    tick();
    chk("col_req", irq_req_adr_o, 16'h0A00);
    rd_chk("col_pending", 4'h1, 16'h0001);

    // Edge to level discards the latched bit
    irq_i = 8'h00;
    repeat (3) tick();
    wr(4'h2, 16'h0000);
    tick();
    rd_chk("mode_discard_pend", 4'h1, 16'h0000);
    chk("mode_discard_req", irq_req_adr_o, 16'h0000);

    // Reset with a request active and an access in flight
    wr(4'h2, 16'h0002);
    wr(4'h0, 16'h0002);
    irq_i = 8'h02;
    tick();
    irq_i = 8'h00;
    repeat (3) tick();
    chk("mid_req", irq_req_adr_o, 16'h0100);
    reg_stb_i  = 1'b1;
    reg_we_i   = 1'b0;
    reg_adr_i  = 4'h0;
    sync_rst_i = 1'b1;
    tick();
    chk("mid_rst_req", irq_req_adr_o, 16'h0000);
    chk("mid_rst_ack", 16'(reg_ack_o), 16'h0000);
    chk("mid_rst_dat", reg_dat_o, 16'h0000);
    sync_rst_i = 1'b0;
    reg_stb_i  = 1'b0;
    tick();
    chk("post_rst_ack", 16'(reg_ack_o), 16'h0000);
    for (int a = 0; a < 16; a++) rd_chk($sformatf("post_rst_reg%0d", a), 4'(a), 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
